// File: rtl/sram_mem_controller.sv
// sram_mem_controller: bridges the MEM stage to a 16-bit external SRAM.
// Each 32-bit load/store is split into two 16-bit phases (low half, then high half),
// each lasting WAIT_CYCLES clocks, while ready is held low to stall the pipeline.
// Optional build macro SRAM_ADDR_CHECK_EN adds an `err` output and rejects requests
// whose address falls outside the SRAM window without touching the SRAM.
module sram_mem_controller #(
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] st_val,
    output logic [31:0] rdata,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
`ifdef SRAM_ADDR_CHECK_EN
    output logic        err,
`endif
    output logic        SRAM_WE_N
);

    localparam int unsigned CntW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {StIdle, StLow, StHigh, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              op_wr_q, op_wr_d;
    logic [16:0]       word_q, word_d;
    logic [31:0]       data_q, data_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              req;
    logic              phase_last;
    logic              addr_bad;
    logic [31:0]       offset;
    logic              dq_oe;
    logic [15:0]       dq_out;
    logic              unused_addr_bits;

    assign req        = wr_en | rd_en;
    assign offset     = address - 32'(BASE_ADDR);
    assign phase_last = (cnt_q == CntW'(WAIT_CYCLES - 1));
    // Only bits [18:2] of the offset form the word address; the rest wrap or are range-checked.
    assign unused_addr_bits = ^{offset[31:19], offset[1:0]};

`ifdef SRAM_ADDR_CHECK_EN
    logic err_q, err_d;
    assign addr_bad = (address < 32'(BASE_ADDR)) | (offset[31:19] != 13'd0);
    assign err      = err_q;
`else
    assign addr_bad = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; DONE always returns to IDLE so a held request is not re-accepted
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    state_d = addr_bad ? StDone : StLow;
                end
            end
            StLow: begin
                if (phase_last) begin
                    state_d = StHigh;
                end
            end
            StHigh: begin
                if (phase_last) begin
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output decode from registered state; only IDLE ready looks at the live request
    always_comb begin
        ready     = 1'b1;
        SRAM_WE_N = 1'b1;
        SRAM_ADDR = 18'd0;
        dq_oe     = 1'b0;
        dq_out    = 16'd0;
        unique case (state_q)
            StIdle: ready = ~(req & rst);
            StLow: begin
                ready     = 1'b0;
                SRAM_ADDR = {word_q, 1'b0};
                SRAM_WE_N = ~op_wr_q;
                dq_oe     = op_wr_q;
                dq_out    = data_q[15:0];
            end
            StHigh: begin
                ready     = 1'b0;
                SRAM_ADDR = {word_q, 1'b1};
                SRAM_WE_N = ~op_wr_q;
                dq_oe     = op_wr_q;
                dq_out    = data_q[31:16];
            end
            StDone: ready = 1'b1;
            default: ready = 1'b1;
        endcase
    end

    assign SRAM_DQ = dq_oe ? dq_out : 16'bz;
    assign rdata   = rdata_q;

    // Datapath next-state: request latch, phase counter and read-data capture
    always_comb begin
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        word_d  = word_q;
        data_d  = data_q;
        rdata_d = rdata_q;
`ifdef SRAM_ADDR_CHECK_EN
        err_d   = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    op_wr_d = wr_en;
                    word_d  = offset[18:2];
                    data_d  = st_val;
                    cnt_d   = '0;
`ifdef SRAM_ADDR_CHECK_EN
                    if (addr_bad) begin
                        err_d = 1'b1;
                        if (!wr_en) begin
                            rdata_d = 32'd0;
                        end
                    end
`endif
                end
            end
            StLow, StHigh: begin
                if (phase_last) begin
                    cnt_d = '0;
                    if (!op_wr_q) begin
                        if (state_q == StLow) begin
                            rdata_d[15:0] = SRAM_DQ;
                        end else begin
                            rdata_d[31:16] = SRAM_DQ;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            op_wr_q <= 1'b0;
            word_q  <= 17'd0;
            data_q  <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            word_q  <= word_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef SRAM_ADDR_CHECK_EN
    // Error flag, high only in the DONE cycle of a rejected request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`endif

endmodule

// File: tb/tb_sram_mem_controller.sv
// Directed self-checking bench for sram_mem_controller with a behavioural 16-bit SRAM.
module tb_sram_mem_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] address = 32'd0;
    logic [31:0] st_val = 32'd0;
    logic [31:0] rdata;
    logic        ready;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_we_n;
`ifdef SRAM_ADDR_CHECK_EN
    logic        err;
`endif

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [0:262143];

    sram_mem_controller #(
        .BASE_ADDR  (1024),
        .WAIT_CYCLES(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .address  (address),
        .st_val   (st_val),
        .rdata    (rdata),
        .ready    (ready),
        .SRAM_DQ  (sram_dq),
        .SRAM_ADDR(sram_addr),
`ifdef SRAM_ADDR_CHECK_EN
        .err      (err),
`endif
        .SRAM_WE_N(sram_we_n)
    );

    always #5 clk = ~clk;

    // SRAM model: drives the bus whenever not being written, writes on the clock edge
    assign sram_dq = sram_we_n ? mem[sram_addr] : 16'hzzzz;

    always @(posedge clk) begin
        if (!sram_we_n) begin
            mem[sram_addr] <= sram_dq;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a request from IDLE, count stalled cycles, hold request through DONE,
    // sample rdata in DONE and return one cycle later in IDLE with the request dropped.
    task automatic access(input logic w, input logic r, input logic [31:0] a,
                          input logic [31:0] d, output int stall, output logic [31:0] rd);
        wr_en   = w;
        rd_en   = r;
        address = a;
        st_val  = d;
        stall   = 0;
        #1;
        while (!ready && stall < 20) begin
            stall++;
            tick();
        end
        rd = rdata;
        tick();
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        st_val = 32'd0;
        #1;
    endtask

    initial begin
        int          stall;
        logic [31:0] rd;

        for (int i = 0; i < 262144; i++) begin
            mem[i] = 16'h5555;
        end

        // Reset with a request pending
        wr_en   = 1'b1;
        address = 32'd1024;
        st_val  = 32'hFFFF_FFFF;
        #12;
        chk("reset_we_n", {31'd0, sram_we_n}, 32'd1);
        chk("reset_ready", {31'd0, ready}, 32'd1);
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_addr", {14'd0, sram_addr}, 32'd0);
        wr_en = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("idle_ready", {31'd0, ready}, 32'd1);

        // Store then load at base address
        access(1'b1, 1'b0, 32'd1024, 32'hDEAD_BEEF, stall, rd);
        chk("st0_stall", stall, 32'd5);
        chk("st0_lo", {16'd0, mem[0]}, 32'h0000_BEEF);
        chk("st0_hi", {16'd0, mem[1]}, 32'h0000_DEAD);
        chk("st0_rdata_kept", rd, 32'd0);
        access(1'b0, 1'b1, 32'd1024, 32'hFFFF_FFFF, stall, rd);
        chk("ld0_stall", stall, 32'd5);
        chk("ld0_rdata", rd, 32'hDEAD_BEEF);
        chk("ld0_rdata_hold", rdata, 32'hDEAD_BEEF);

        // Address mapping and untouched neighbours
        access(1'b1, 1'b0, 32'd1032, 32'h1234_5678, stall, rd);
        chk("st8_lo", {16'd0, mem[4]}, 32'h0000_5678);
        chk("st8_hi", {16'd0, mem[5]}, 32'h0000_1234);
        access(1'b0, 1'b1, 32'd1036, 32'hFFFF_FFFF, stall, rd);
        chk("ld12_rdata", rd, 32'h5555_5555);
        chk("ld12_keep_lo", {16'd0, mem[4]}, 32'h0000_5678);
        chk("ld12_keep_hi", {16'd0, mem[5]}, 32'h0000_1234);

        // Simultaneous request: write wins, rdata untouched
        access(1'b1, 1'b1, 32'd1028, 32'hA5A5_5A5A, stall, rd);
        chk("both_stall", stall, 32'd5);
        chk("both_lo", {16'd0, mem[2]}, 32'h0000_5A5A);
        chk("both_hi", {16'd0, mem[3]}, 32'h0000_A5A5);
        chk("both_rdata", rd, 32'h5555_5555);

        // Reset during the HIGH phase of a store to word 4 (half-words 8/9)
        wr_en   = 1'b1;
        address = 32'd1040;
        st_val  = 32'h1111_2222;
        tick();
        tick();
        tick();
        chk("mid_we_low", {31'd0, sram_we_n}, 32'd0);
        chk("mid_addr_high", {14'd0, sram_addr}, 32'd9);
        wr_en = 1'b0;
        rst   = 1'b0;
        #1;
        chk("mid_rst_we_n", {31'd0, sram_we_n}, 32'd1);
        chk("mid_rst_ready", {31'd0, ready}, 32'd1);
        tick();
        rst = 1'b1;
        tick();
        chk("mid_lo_written", {16'd0, mem[8]}, 32'h0000_2222);
        chk("mid_hi_untouched", {16'd0, mem[9]}, 32'h0000_5555);
        chk("mid_rdata_cleared", rdata, 32'd0);
        access(1'b1, 1'b0, 32'd1044, 32'h0BAD_F00D, stall, rd);
        chk("post_rst_stall", stall, 32'd5);
        chk("post_rst_lo", {16'd0, mem[10]}, 32'h0000_F00D);

        // Back-to-back: load held through DONE, then store on the next cycle
        access(1'b0, 1'b1, 32'd1024, 32'hFFFF_FFFF, stall, rd);
        chk("b2b_ld_stall", stall, 32'd5);
        chk("b2b_ld_rdata", rd, 32'hDEAD_BEEF);
        chk("b2b_no_reaccept", {31'd0, ready}, 32'd1);
        access(1'b1, 1'b0, 32'd1028, 32'h0102_0304, stall, rd);
        chk("b2b_st_stall", stall, 32'd5);
        chk("b2b_st_lo", {16'd0, mem[2]}, 32'h0000_0304);
        chk("b2b_st_hi", {16'd0, mem[3]}, 32'h0000_0102);

`ifdef SRAM_ADDR_CHECK_EN
        // Out-of-range load: straight to DONE with err, no SRAM activity
        chk("err_idle", {31'd0, err}, 32'd0);
        rd_en   = 1'b1;
        address = 32'd0;
        st_val  = 32'hFFFF_FFFF;
        #1;
        chk("err_accept_ready", {31'd0, ready}, 32'd0);
        tick();
        chk("err_done_ready", {31'd0, ready}, 32'd1);
        chk("err_flag", {31'd0, err}, 32'd1);
        chk("err_rdata", rdata, 32'd0);
        chk("err_we_n", {31'd0, sram_we_n}, 32'd1);
        rd_en = 1'b0;
        tick();
        chk("err_clear", {31'd0, err}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_mem_controller.md
Name: sram_mem_controller

Overview:
- Memory-stage bridge between the ARM pipeline's MEM stage and the external 16-bit SRAM (SRAM_DQ / SRAM_ADDR / SRAM_WE_N).
- Turns one 32-bit load/store into two 16-bit SRAM phases (low half, then high half).
- Holds `ready` low to freeze the pipeline until the access completes.
- Sits inside Arm, directly upstream of the SRAM model.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM word 0.
- WAIT_CYCLES, 2: cycles each 16-bit phase occupies, ≥1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset (0 = reset).
- wr_en  input  1  store request from MEM stage.
- rd_en  input  1  load request from MEM stage.
- address  input  32  byte address from ALU result, word-aligned.
- st_val  input  32  store data.
- rdata  output  32  load data, valid while ready=1 in DONE.
- ready  output  1  0 = freeze pipeline.
- SRAM_DQ  inout  16  SRAM data bus.
- SRAM_ADDR  output  18  SRAM half-word address.
- SRAM_WE_N  output  1  SRAM write enable, active-low.

Behaviour:
- Reset (rst=0, async, also mid-access):
  - state=IDLE, phase counter=0, latched addr/data=0, rdata=0.
  - SRAM_WE_N=1, SRAM_ADDR=0, SRAM_DQ=Z, ready=1.
  - Any in-flight access is abandoned; no partial-write rollback.
- States: IDLE, LOW, HIGH, DONE.
- IDLE:
  - Request: req = wr_en | rd_en.
  - ready = ~req (combinational).
  - On req, latch at the clock edge: op (write if wr_en, write wins when both are set), word = (address − BASE_ADDR) >> 2 truncated to 17 bits, st_val. Then go to LOW, counter=0.
- LOW:
  - SRAM_ADDR = {word, 1'b0}.
  - Write: SRAM_WE_N=0, SRAM_DQ = data[15:0].
  - Read: SRAM_WE_N=1, SRAM_DQ=Z.
  - Counter increments each cycle. On the cycle with counter = WAIT_CYCLES−1: a read captures SRAM_DQ into rdata[15:0], counter clears, state goes to HIGH.
- HIGH:
  - Same as LOW, with SRAM_ADDR = {word, 1'b1} and data[31:16] / rdata[31:16].
  - Then go to DONE.
- DONE:
  - ready=1 for exactly one cycle; SRAM_WE_N=1, SRAM_DQ=Z.
  - Next state is IDLE unconditionally. A request still asserted in DONE is the completing one and is not re-accepted.
- ready and SRAM outputs decode from registered state only (no combinational path from inputs), except ready in IDLE.
- Latency: ready=0 for 2*WAIT_CYCLES+1 consecutive cycles per access (5 with default), then ready=1 in DONE.
- rdata holds its last value until overwritten by a later read. Writes do not modify rdata.
- SRAM_DQ is driven only during write LOW/HIGH cycles; it is Z at all other times.
- Address math:
  - Unsigned subtraction, then bits [18:2]. Addresses below BASE_ADDR wrap silently (unless the optional feature is enabled).
  - address[1:0] is ignored.

Optional Feature:
- Macro: SRAM_ADDR_CHECK_EN.
- Defined:
  - Adds output port `err` (1 bit), reset 0.
  - In IDLE, a request with address < BASE_ADDR or (address − BASE_ADDR) ≥ 2^19 goes directly to DONE.
  - No SRAM cycles are issued and SRAM_WE_N stays 1.
  - rdata is set to 0 for reads.
  - err=1 only during that DONE cycle; ready=0 for only the accept cycle.
- Undefined: no `err` port; out-of-range addresses wrap as above.

Test Plan:
1. Reset: hold rst=0 with wr_en=1 → SRAM_WE_N=1, SRAM_DQ=Z, ready=1, rdata=0; release rst → normal operation.
2. Store, then load:
   - wr_en=1, address=1024, st_val=0xDEADBEEF → SRAM half-word 0 = 0xBEEF, half-word 1 = 0xDEAD.
   - ready=0 for exactly 5 cycles, then 1 for one cycle.
   - Then rd_en=1 at address 1024 → rdata=0xDEADBEEF in DONE.
3. Mapping: store 0x12345678 at address 1032 → SRAM_ADDR=4 carries 0x5678 and SRAM_ADDR=5 carries 0x1234. Load 1036 (never written) → no corruption of 4/5.
4. Simultaneous: wr_en=1 and rd_en=1, address=1028, st_val=0xA5A5_5A5A → write performed (SRAM_WE_N low in LOW/HIGH); rdata unchanged.
5. Reset mid-access: assert rst=0 during HIGH of a store → immediately SRAM_WE_N=1, SRAM_DQ=Z, state IDLE. Half-word 2k already written; 2k+1 not written; next request starts in LOW.
6. Back-to-back: load 1024, then store 1028 on the cycle after DONE → second access accepted in IDLE, ready low 5 cycles again, no double-accept of the load. With SRAM_ADDR_CHECK_EN: load at 0x0 → err=1 for one cycle, rdata=0, no SRAM activity.
